// File: rtl/half_sub.sv
// Registered multi-lane half subtractor: per-lane diff/borrow, an OR-reduced
// borrow flag and a saturating count of accepted samples that produced a borrow.
module half_sub #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid,
  output logic             borrow_any,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] borrow_next;
  logic             borrow_any_next;
  logic [CNT_W-1:0] borrow_cnt_next;

  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] borrow_reg;
  logic             out_valid_reg;
  logic             borrow_any_reg;
  logic [CNT_W-1:0] borrow_cnt_reg;

  // Lanes are independent: no borrow ripples between neighbouring bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign diff_next[gi]   = a[gi] ^ b[gi];
    assign borrow_next[gi] = ~a[gi] & b[gi];
  end

  assign borrow_any_next = |borrow_next;

  always_comb begin
    borrow_cnt_next = borrow_cnt_reg;
    if (in_valid && borrow_any_next && (borrow_cnt_reg != CNT_MAX))
      borrow_cnt_next = borrow_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_reg       <= '0;
      borrow_reg     <= '0;
      out_valid_reg  <= 1'b0;
      borrow_any_reg <= 1'b0;
      borrow_cnt_reg <= '0;
    end else begin
      out_valid_reg  <= in_valid;
      borrow_cnt_reg <= borrow_cnt_next;
      // Results hold their last captured value across invalid cycles.
      if (in_valid) begin
        diff_reg       <= diff_next;
        borrow_reg     <= borrow_next;
        borrow_any_reg <= borrow_any_next;
      end
    end
  end

  assign diff       = diff_reg;
  assign borrow     = borrow_reg;
  assign out_valid  = out_valid_reg;
  assign borrow_any = borrow_any_reg;
  assign borrow_cnt = borrow_cnt_reg;

endmodule

// File: tb/tb_half_sub.sv
// Directed bench for half_sub: three instances (1-lane, 4-lane with a 2-bit
// counter, 2-lane) driven from hand-computed vector tables.
module tb_half_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=1, CNT_W=8
  logic       v_a = 1'b0;
  logic [0:0] a_a = '0, b_a = '0, d_a, br_a;
  logic       ov_a, any_a;
  logic [7:0] cnt_a;
  // Instance B: WIDTH=4, CNT_W=2
  logic       v_b = 1'b0;
  logic [3:0] a_b = '0, b_b = '0, d_b, br_b;
  logic       ov_b, any_b;
  logic [1:0] cnt_b;
  // Instance C: WIDTH=2, CNT_W=8
  logic       v_c = 1'b0;
  logic [1:0] a_c = '0, b_c = '0, d_c, br_c;
  logic       ov_c, any_c;
  logic [7:0] cnt_c;

  half_sub #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(v_a), .a(a_a), .b(b_a),
    .diff(d_a), .borrow(br_a), .out_valid(ov_a), .borrow_any(any_a), .borrow_cnt(cnt_a));
  half_sub #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(v_b), .a(a_b), .b(b_b),
    .diff(d_b), .borrow(br_b), .out_valid(ov_b), .borrow_any(any_b), .borrow_cnt(cnt_b));
  half_sub #(.WIDTH(2), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(v_c), .a(a_c), .b(b_c),
    .diff(d_c), .borrow(br_c), .out_valid(ov_c), .borrow_any(any_c), .borrow_cnt(cnt_c));

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " A all"}, {23'd0, d_a, br_a, ov_a, any_a, cnt_a}, 32'd0);
    check({tag, " B all"}, {20'd0, d_b, br_b, ov_b, any_b, cnt_b}, 32'd0);
    check({tag, " C all"}, {18'd0, d_c, br_c, ov_c, any_c, cnt_c}, 32'd0);
  endtask

  // Lane truth table {a,b} -> {diff,borrow}: 00->00, 01->11, 10->10, 11->00
  logic [1:0] lut [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

  // WIDTH=1 vectors {a,b}, expected {diff,borrow}
  logic [1:0] w1_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] w1_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
  int unsigned sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    int exp_cnt_c;
    logic [1:0] ea, eb, ed, ebr;

    // Reset state
    step(); step();
    check_zero("reset");
    rst = 1'b0;

    // WIDTH=1 truth table, back to back
    for (int i = 0; i < 4; i++) begin
      v_a = 1'b1; a_a = w1_in[i][1]; b_a = w1_in[i][0];
      step();
      check($sformatf("w1 vec%0d diff/borrow/ov", i), {29'd0, d_a, br_a, ov_a},
            {29'd0, w1_exp[i], 1'b1});
    end
    check("w1 borrow_cnt", {24'd0, cnt_a}, 32'd1);

    // Valid gap: inputs that would borrow are ignored
    v_a = 1'b0; a_a = 1'b0; b_a = 1'b1;
    step();
    check("gap diff/borrow/ov/any", {28'd0, d_a, br_a, ov_a, any_a}, 32'd0);
    check("gap borrow_cnt", {24'd0, cnt_a}, 32'd1);

    // Saturation on 2-bit counter
    for (int i = 0; i < 5; i++) begin
      v_b = 1'b1; a_b = 4'b0000; b_b = 4'b0001;
      step();
      check($sformatf("sat cnt%0d", i), {30'd0, cnt_b}, sat_exp[i]);
    end

    // WIDTH=4 mixed lanes
    a_b = 4'b0101; b_b = 4'b0011;
    step();
    check("w4 diff", {28'd0, d_b}, 32'h6);
    check("w4 borrow", {28'd0, br_b}, 32'h2);
    check("w4 any/ov", {30'd0, any_b, ov_b}, 32'h3);
    a_b = 4'b1111; b_b = 4'b0000;
    step();
    check("w4 no borrow any", {27'd0, d_b, any_b}, {27'd0, 4'hF, 1'b0});
    v_b = 1'b0;
    step();
    check("w4 ov drops", {31'd0, ov_b}, 32'd0);

    // WIDTH=2 exhaustive sweep
    exp_cnt_c = 0;
    for (int i = 0; i < 16; i++) begin
      ea = i[3:2]; eb = i[1:0];
      v_c = 1'b1; a_c = ea; b_c = eb;
      for (int l = 0; l < 2; l++) begin
        ed[l]  = lut[{ea[l], eb[l]}][1];
        ebr[l] = lut[{ea[l], eb[l]}][0];
      end
      if (ebr != 2'b00) exp_cnt_c++;
      step();
      check($sformatf("w2 a=%b b=%b", ea, eb), {26'd0, d_c, br_c, ov_c, any_c},
            {26'd0, ed, ebr, 1'b1, |ebr});
    end
    check("w2 borrow_cnt", {24'd0, cnt_c}, exp_cnt_c);
    v_c = 1'b0;

    // Reset mid-stream with a borrowing sample present
    v_a = 1'b1; a_a = 1'b0; b_a = 1'b1;
    v_b = 1'b1; a_b = 4'b0000; b_b = 4'b0001;
    v_c = 1'b1; a_c = 2'b00; b_c = 2'b01;
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    step();
    check("post-rst A", {28'd0, d_a, br_a, ov_a, any_a}, 32'hF);
    check("post-rst A cnt", {24'd0, cnt_a}, 32'd1);
    check("post-rst B cnt", {30'd0, cnt_b}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/half_sub.md
HALF_SUB -- requirements
Module: half_sub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1, SHALL set the number of independent bit-lanes.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the borrow-event counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  qualifies a and b in the current cycle.
REQ-007 a  input  WIDTH  minuend, one bit per lane.
REQ-008 b  input  WIDTH  subtrahend, one bit per lane.
REQ-009 diff  output  WIDTH  registered per-lane difference.
REQ-010 borrow  output  WIDTH  registered per-lane borrow-out.
REQ-011 out_valid  output  1  high when diff and borrow hold a newly captured result.
REQ-012 borrow_any  output  1  registered OR-reduction of the captured borrow vector.
REQ-013 borrow_cnt  output  CNT_W  saturating count of accepted samples with borrow_any set.
REQ-014 Port order SHALL be clk, rst, in_valid, a, b, diff, borrow, out_valid, borrow_any, borrow_cnt.

Function
REQ-015 Each lane i SHALL compute diff[i] = a[i] XOR b[i].
REQ-016 Each lane i SHALL compute borrow[i] = (NOT a[i]) AND b[i].
REQ-017 Lane truth table (a,b -> diff,borrow): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
REQ-018 Lanes SHALL be fully independent; there SHALL be no borrow propagation between lanes.
REQ-019 The result SHALL be registered with a latency of exactly one clock: inputs sampled at edge N with in_valid=1 appear on the outputs after edge N.
REQ-020 out_valid SHALL equal in_valid delayed by one clock.
REQ-021 When in_valid=0, diff, borrow and borrow_any SHALL hold their previous values, and out_valid SHALL be 0 after the edge.
REQ-022 borrow_any SHALL be updated in the same cycle as diff and borrow, and SHALL equal the OR of the borrow vector.
REQ-023 borrow_cnt SHALL increment by 1 on each accepted sample (in_valid=1) whose computed borrow vector is nonzero.
REQ-024 borrow_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 Back-to-back valid samples SHALL be accepted every cycle with no stall.
REQ-026 X-free outputs SHALL be guaranteed from the first edge after reset.

Reset
REQ-027 When rst=1 at a rising edge, diff, borrow, out_valid, borrow_any and borrow_cnt SHALL all become 0.
REQ-028 rst SHALL take priority over in_valid; a sample presented in a reset cycle SHALL be discarded and not counted.
REQ-029 Reset asserted mid-stream SHALL clear all state; the first valid sample after rst deasserts SHALL produce its result one clock later.

Verification
REQ-030 WIDTH=1: apply (a,b) = 00, 01, 10, 11 with in_valid=1 on consecutive cycles -> one cycle later diff/borrow = 0/0, 1/1, 1/0, 0/0, out_valid=1 throughout, borrow_cnt=1.
REQ-031 WIDTH=4: apply a=4'b0101, b=4'b0011 -> diff=4'b0110, borrow=4'b0010, borrow_any=1 after one clock.
REQ-032 Valid gap: valid sample a=1,b=1 followed by in_valid=0 with a=0,b=1 -> diff=0, borrow=0 held, out_valid drops to 0, and borrow_cnt is unchanged.
REQ-033 Saturation: CNT_W=2, apply 5 consecutive samples with a=0,b=1 -> borrow_cnt reads 1, 2, 3, 3, 3.
REQ-034 Reset mid-stream: assert rst with in_valid=1, a=0, b=1 -> all outputs are 0 on the next edge and borrow_cnt is not incremented.
REQ-035 Exhaustive: WIDTH=2, sweep all 16 (a,b) combinations -> every lane matches REQ-017 with one-cycle latency.
